apb_master_bridge: RTL and testbench

APB4 initiator (requester) for the peripheral subsystem. It accepts single read/write commands on a valid/ready command port and runs each one as an APB4 SETUP/ACCESS transfer. It decodes the slave select one-hot from the upper address bits and returns read data and error status on a valid/ready response port. It drives the slave-side wrapper directly, with out-of-range decode and PREADY-timeout protection.

---
 rtl/apb_master_bridge_if.sv | 49 ++++
 rtl/apb_master_bridge.sv | 172 +++++++++++++++++
 tb/tb_apb_master_bridge.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB4 requester signals of the bridge, bundled for port hookup.
// master = bridge view, slave = command source / APB completer / response sink view.
interface apb_master_bridge_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int SLV_CNT    = 4
) ();
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [ADDR_WIDTH-1:0]     cmd_addr;
   logic                      cmd_write;
   logic [DATA_WIDTH-1:0]     cmd_wdata;
   logic [DATA_WIDTH/8-1:0]   cmd_strb;
   logic [2:0]                cmd_prot;

   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [DATA_WIDTH-1:0]     rsp_rdata;
   logic                      rsp_err;

   logic [ADDR_WIDTH-1:0]     PADDR;
   logic [SLV_CNT-1:0]        PSELx;
   logic                      PENABLE;
   logic                      PWRITE;
   logic [DATA_WIDTH-1:0]     PWDATA;
   logic [DATA_WIDTH/8-1:0]   PSTRB;
   logic [2:0]                PPROT;
   logic                      PREADY;
   logic [DATA_WIDTH-1:0]     PRDATA;
   logic                      PSLVERR;

   modport master (
      input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      input  rsp_ready,
      output PADDR, PSELx, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
      input  PREADY, PRDATA, PSLVERR
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      output rsp_ready,
      input  PADDR, PSELx, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
      output PREADY, PRDATA, PSLVERR
   );
endinterface

// File: rtl/apb_master_bridge.sv
// APB4 requester: one command at a time, SETUP/ACCESS with decode-error and PREADY-timeout aborts.
// Zero-wait latency 3 cycles accept-to-response; cmd_ready only in IDLE, response held until rsp_ready.
module apb_master_bridge #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int SLV_ADDR_WIDTH = 8,
   parameter int SLV_CNT        = 4,
   parameter int TIMEOUT        = 16
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   apb_master_bridge_if.master  bus
);

   localparam int IDX_W = ADDR_WIDTH - SLV_ADDR_WIDTH;
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic [SLV_CNT-1:0]      psel_q, psel_d;
   logic                    penable_q, penable_d;
   logic                    pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
   logic [STRB_W-1:0]       pstrb_q, pstrb_d;
   logic [2:0]              pprot_q, pprot_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic [IDX_W-1:0]        idx;
   logic                    idx_ok;
   logic                    timeout_hit;

   assign idx    = bus.cmd_addr[ADDR_WIDTH-1:SLV_ADDR_WIDTH];
   assign idx_ok = (32'(idx) < SLV_CNT);
   // cnt_q counts completed wait cycles of this ACCESS phase, so TIMEOUT-1 marks the last allowed one.
   assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 1);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= S_IDLE;
         paddr_q     <= '0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         pprot_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         pprot_q     <= pprot_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      pprot_d     = pprot_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      cnt_d       = cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               if (idx_ok) begin
                  paddr_d   = bus.cmd_addr;
                  pwrite_d  = bus.cmd_write;
                  pwdata_d  = bus.cmd_wdata;
                  pprot_d   = bus.cmd_prot;
                  pstrb_d   = bus.cmd_write ? bus.cmd_strb : '0;
                  psel_d    = SLV_CNT'(1) << idx;
                  penable_d = 1'b0;
                  state_d   = S_SETUP;
               end else begin
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
                  rsp_valid_d = 1'b1;
                  state_d     = S_RESP;
               end
            end
         end

         S_SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_ACCESS;
         end

         S_ACCESS: begin
            // PREADY is checked first so a completion on the timeout cycle is not an error.
            if (bus.PREADY) begin
               rsp_rdata_d = (pwrite_q || bus.PSLVERR) ? '0 : bus.PRDATA;
               rsp_err_d   = bus.PSLVERR;
               psel_d      = '0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (timeout_hit) begin
                  psel_d      = '0;
                  penable_d   = 1'b0;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
                  rsp_valid_d = 1'b1;
                  state_d     = S_RESP;
               end
            end
         end

         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PSELx     = psel_q;
   assign bus.PENABLE   = penable_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PWDATA    = pwdata_q;
   assign bus.PSTRB     = pstrb_q;
   assign bus.PPROT     = pprot_q;

   a_psel_onehot: assert property (@(posedge PCLK) disable iff (!PRESETn) $onehot0(psel_q));
   a_penable_sel: assert property (@(posedge PCLK) disable iff (!PRESETn) penable_q |-> (psel_q != '0));

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed scenarios plus randomized transfers against a transaction-level model.
module tb_apb_master_bridge;

   localparam int DW  = 32;
   localparam int AW  = 10;
   localparam int SAW = 8;
   localparam int SC  = 3;
   localparam int TO  = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   apb_master_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLV_CNT(SC)) bus ();

   apb_master_bridge #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLV_ADDR_WIDTH(SAW), .SLV_CNT(SC), .TIMEOUT(TO)
   ) dut (
      .PCLK(clk), .PRESETn(rst_n), .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          cmd_rdy;
      int          psel_cyc;
      logic [2:0]  psel;
      logic [9:0]  paddr;
      logic        pwrite;
      logic [31:0] pwdata;
      logic [3:0]  pstrb;
      logic [2:0]  pprot;
      int          pen_cnt;
      int          rsp_cyc;
      logic [31:0] rdata;
      logic        err;
      int          bad_bus;
      int          unstable;
      int          hold_bad;
      int          idle_at_rsp;
      logic        vld_after;
      logic        rdy_after;
   } obs_t;

   typedef struct {
      logic        dec_err;
      logic [2:0]  psel;
      int          psel_cyc;
      int          pen_cnt;
      int          rsp_cyc;
      logic [31:0] rdata;
      logic        err;
      logic [3:0]  pstrb;
   } exp_t;

   // Transaction-level expectation: slave window from the upper address bits, wait count vs timeout budget.
   function automatic exp_t model(input logic [9:0] addr, input logic wr, input logic [3:0] strb,
                                  input int waits, input logic slverr, input logic [31:0] prdata);
      exp_t e;
      int idx;
      logic timed;
      idx = int'(addr) / 256;
      e.dec_err = (idx >= SC);
      e.pstrb = wr ? strb : 4'h0;
      if (e.dec_err) begin
         e.psel = 3'b000; e.psel_cyc = -1; e.pen_cnt = 0; e.rsp_cyc = 1;
         e.rdata = 32'h0; e.err = 1'b1;
      end else begin
         timed = (waits >= TO);
         e.psel = 3'(1 << idx);
         e.psel_cyc = 1;
         e.pen_cnt = timed ? TO : waits + 1;
         e.rsp_cyc = e.pen_cnt + 2;
         e.err = timed || slverr;
         e.rdata = (wr || e.err) ? 32'h0 : prdata;
      end
      return e;
   endfunction

   // Drives one command at a negedge, plays a completer with 'waits' low-PREADY cycles, and records what it sees.
   task automatic do_txn(input logic [9:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot, input int waits,
                         input logic slverr, input logic [31:0] prdata, input int hold,
                         output obs_t o);
      int cyc;
      int k;
      o = '{default: 0};
      o.psel_cyc = -1;
      o.rsp_cyc = -1;
      bus.cmd_addr = addr; bus.cmd_write = wr; bus.cmd_wdata = wdata;
      bus.cmd_strb = strb; bus.cmd_prot = prot; bus.cmd_valid = 1'b1;
      bus.rsp_ready = 1'b0;
      o.cmd_rdy = int'(bus.cmd_ready);
      cyc = 0;
      while (cyc < 100) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         bus.cmd_addr = 10'($urandom);
         if ($countones(bus.PSELx) > 1) o.bad_bus++;
         if (bus.PENABLE && bus.PSELx == 3'b000) o.bad_bus++;
         if (bus.PSELx != 3'b000) begin
            if (o.psel_cyc < 0) begin
               o.psel_cyc = cyc; o.psel = bus.PSELx; o.paddr = bus.PADDR; o.pwrite = bus.PWRITE;
               o.pwdata = bus.PWDATA; o.pstrb = bus.PSTRB; o.pprot = bus.PPROT;
            end else if ({bus.PSELx, bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB, bus.PPROT} !==
                         {o.psel, o.paddr, o.pwrite, o.pwdata, o.pstrb, o.pprot}) begin
               o.unstable++;
            end
         end
         if (bus.PENABLE) o.pen_cnt++;
         if (bus.rsp_valid) begin
            o.rsp_cyc = cyc; o.rdata = bus.rsp_rdata; o.err = bus.rsp_err;
            o.idle_at_rsp = int'(bus.PSELx == 3'b000 && !bus.PENABLE);
            break;
         end
         if (bus.PENABLE) begin
            k = o.pen_cnt - 1;
            bus.PREADY  = (k == waits);
            bus.PRDATA  = (k == waits) ? prdata : $urandom;
            bus.PSLVERR = (k == waits) ? slverr : 1'($urandom);
         end else begin
            bus.PREADY  = 1'($urandom);
            bus.PRDATA  = $urandom;
            bus.PSLVERR = 1'($urandom);
         end
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         if (!bus.rsp_valid || bus.rsp_rdata !== o.rdata || bus.rsp_err !== o.err || bus.cmd_ready)
            o.hold_bad++;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      o.vld_after = bus.rsp_valid;
      o.rdy_after = bus.cmd_ready;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if ({bus.PSELx, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got sel=%b en=%b wr=%b vld=%b err=%b, want all 0",
                  bus.PSELx, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err);
      end
      n_cmp++;
      if ({bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT, bus.rsp_rdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_data: got addr=%h wdata=%h strb=%h prot=%h rdata=%h, want all 0",
                  bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT, bus.rsp_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.cmd_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready);
      end
   endtask

   task automatic test_write_zero_wait();
      obs_t o;
      do_txn(10'h104, 1'b1, 32'hDEADBEEF, 4'hF, 3'b010, 0, 1'b0, 32'h0, 0, o);
      n_cmp++; if (o.psel !== 3'b010 || o.psel_cyc != 1) begin
         n_bad++; $display("FAIL wr_psel: got %b at cyc %0d, want 010 at cyc 1", o.psel, o.psel_cyc); end
      n_cmp++; if (o.paddr !== 10'h104 || o.pwdata !== 32'hDEADBEEF || o.pstrb !== 4'hF || o.pwrite !== 1'b1) begin
         n_bad++; $display("FAIL wr_payload: got addr=%h wdata=%h strb=%h wr=%b, want 104 deadbeef f 1",
                           o.paddr, o.pwdata, o.pstrb, o.pwrite); end
      n_cmp++; if (o.pen_cnt != 1 || o.rsp_cyc != 3) begin
         n_bad++; $display("FAIL wr_latency: got penable=%0d rsp_cyc=%0d, want 1 and 3", o.pen_cnt, o.rsp_cyc); end
      n_cmp++; if (o.err !== 1'b0 || o.rdata !== 32'h0) begin
         n_bad++; $display("FAIL wr_rsp: got err=%b rdata=%h, want 0 0", o.err, o.rdata); end
   endtask

   task automatic test_read_waits();
      obs_t o;
      do_txn(10'h2F0, 1'b0, 32'hA5A5A5A5, 4'hF, 3'b001, 3, 1'b0, 32'h12345678, 0, o);
      n_cmp++; if (o.psel !== 3'b100 || o.pstrb !== 4'h0) begin
         n_bad++; $display("FAIL rd_sel_strb: got sel=%b strb=%h, want 100 0", o.psel, o.pstrb); end
      n_cmp++; if (o.pen_cnt != 4 || o.rsp_cyc != 6) begin
         n_bad++; $display("FAIL rd_wait: got penable=%0d rsp_cyc=%0d, want 4 and 6", o.pen_cnt, o.rsp_cyc); end
      n_cmp++; if (o.rdata !== 32'h12345678 || o.err !== 1'b0) begin
         n_bad++; $display("FAIL rd_data: got rdata=%h err=%b, want 12345678 0", o.rdata, o.err); end
   endtask

   task automatic test_decode_err();
      obs_t o;
      do_txn(10'h3FC, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0, 0, o);
      n_cmp++; if (o.psel_cyc != -1 || o.pen_cnt != 0) begin
         n_bad++; $display("FAIL dec_noapb: got psel_cyc=%0d penable=%0d, want -1 0", o.psel_cyc, o.pen_cnt); end
      n_cmp++; if (o.rsp_cyc != 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
         n_bad++; $display("FAIL dec_rsp: got cyc=%0d err=%b rdata=%h, want 1 1 0", o.rsp_cyc, o.err, o.rdata); end
   endtask

   task automatic test_timeout();
      obs_t o;
      do_txn(10'h010, 1'b0, 32'h0, 4'h0, 3'b000, 1000, 1'b0, 32'h0, 0, o);
      n_cmp++; if (o.pen_cnt != TO || o.rsp_cyc != TO + 2 || o.idle_at_rsp != 1) begin
         n_bad++; $display("FAIL to_abort: got penable=%0d rsp_cyc=%0d idle=%0d, want %0d %0d 1",
                           o.pen_cnt, o.rsp_cyc, o.idle_at_rsp, TO, TO + 2); end
      n_cmp++; if (o.err !== 1'b1 || o.rdata !== 32'h0) begin
         n_bad++; $display("FAIL to_rsp: got err=%b rdata=%h, want 1 0", o.err, o.rdata); end
      do_txn(10'h1C0, 1'b0, 32'h0, 4'h0, 3'b000, TO - 1, 1'b0, 32'hCAFE0001, 0, o);
      n_cmp++; if (o.pen_cnt != TO || o.err !== 1'b0 || o.rdata !== 32'hCAFE0001) begin
         n_bad++; $display("FAIL to_edge: got penable=%0d err=%b rdata=%h, want %0d 0 cafe0001",
                           o.pen_cnt, o.err, o.rdata, TO); end
   endtask

   task automatic test_slverr_hold();
      obs_t o;
      do_txn(10'h088, 1'b0, 32'h0, 4'h0, 3'b100, 1, 1'b1, 32'h0000FFFF, 5, o);
      n_cmp++; if (o.err !== 1'b1 || o.rdata !== 32'h0) begin
         n_bad++; $display("FAIL slverr_rsp: got err=%b rdata=%h, want 1 0", o.err, o.rdata); end
      n_cmp++; if (o.hold_bad != 0) begin
         n_bad++; $display("FAIL slverr_hold: got %0d unstable hold cycles, want 0", o.hold_bad); end
      n_cmp++; if (o.vld_after !== 1'b0 || o.rdy_after !== 1'b1) begin
         n_bad++; $display("FAIL slverr_release: got vld=%b rdy=%b, want 0 1", o.vld_after, o.rdy_after); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.cmd_addr = 10'h0A0; bus.cmd_write = 1'b0; bus.cmd_valid = 1'b1;
      bus.PREADY = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      n_cmp++; if (bus.PENABLE !== 1'b1 || bus.PSELx !== 3'b001) begin
         n_bad++; $display("FAIL mid_access: got en=%b sel=%b, want 1 001", bus.PENABLE, bus.PSELx); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.PSELx !== 3'b000 || bus.PENABLE !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         n_bad++; $display("FAIL mid_async: got sel=%b en=%b vld=%b, want 0 0 0",
                           bus.PSELx, bus.PENABLE, bus.rsp_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      bus.PREADY = 1'b1;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      n_cmp++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.PSELx !== 3'b000) begin
         n_bad++; $display("FAIL mid_after: got rdy=%b vld=%b sel=%b, want 1 0 000",
                           bus.cmd_ready, bus.rsp_valid, bus.PSELx); end
   endtask

   task automatic test_random();
      obs_t o;
      exp_t e;
      logic [9:0] addr;
      logic wr, se;
      logic [31:0] wd, rd;
      logic [3:0] st;
      logic [2:0] pr;
      int r, waits, hold;
      for (int n = 0; n < 40; n++) begin
         addr = 10'($urandom); wr = 1'($urandom); wd = $urandom; rd = $urandom;
         st = 4'($urandom); pr = 3'($urandom); se = ($urandom_range(0, 3) == 0);
         r = $urandom_range(0, 9);
         waits = (r < 7) ? r : ((r == 7) ? TO - 1 : ((r == 8) ? TO : 2));
         hold = $urandom_range(0, 3);
         e = model(addr, wr, st, waits, se, rd);
         do_txn(addr, wr, wd, st, pr, waits, se, rd, hold, o);
         n_cmp++; if (o.cmd_rdy != 1) begin
            n_bad++; $display("FAIL rnd%0d_cmd_ready: got %0d want 1", n, o.cmd_rdy); end
         n_cmp++; if (o.psel !== e.psel || o.psel_cyc != e.psel_cyc) begin
            n_bad++; $display("FAIL rnd%0d_psel: got %b@%0d want %b@%0d", n, o.psel, o.psel_cyc, e.psel, e.psel_cyc); end
         if (!e.dec_err) begin
            n_cmp++; if (o.paddr !== addr || o.pwrite !== wr || o.pwdata !== wd || o.pstrb !== e.pstrb || o.pprot !== pr) begin
               n_bad++; $display("FAIL rnd%0d_payload: got %h %b %h %h %h want %h %b %h %h %h", n,
                                 o.paddr, o.pwrite, o.pwdata, o.pstrb, o.pprot, addr, wr, wd, e.pstrb, pr); end
         end
         n_cmp++; if (o.pen_cnt != e.pen_cnt || o.rsp_cyc != e.rsp_cyc) begin
            n_bad++; $display("FAIL rnd%0d_timing: got pen=%0d rsp=%0d want pen=%0d rsp=%0d", n,
                              o.pen_cnt, o.rsp_cyc, e.pen_cnt, e.rsp_cyc); end
         n_cmp++; if (o.rdata !== e.rdata || o.err !== e.err) begin
            n_bad++; $display("FAIL rnd%0d_rsp: got rdata=%h err=%b want rdata=%h err=%b", n, o.rdata, o.err, e.rdata, e.err); end
         n_cmp++; if (o.bad_bus != 0 || o.unstable != 0 || o.hold_bad != 0 || o.idle_at_rsp != 1) begin
            n_bad++; $display("FAIL rnd%0d_protocol: got bad=%0d unstable=%0d hold=%0d idle=%0d want 0 0 0 1", n,
                              o.bad_bus, o.unstable, o.hold_bad, o.idle_at_rsp); end
         n_cmp++; if (o.vld_after !== 1'b0 || o.rdy_after !== 1'b1) begin
            n_bad++; $display("FAIL rnd%0d_release: got vld=%b rdy=%b want 0 1", n, o.vld_after, o.rdy_after); end
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_write = 1'b0; bus.cmd_wdata = '0;
      bus.cmd_strb = '0; bus.cmd_prot = '0; bus.rsp_ready = 1'b0;
      bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
      test_reset();
      test_write_zero_wait();
      test_read_waits();
      test_decode_err();
      test_timeout();
      test_slverr_hold();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
